// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Round-robin arbiter with a rotating pointer, masked priority
//             search, registered one-hot/binary grant and hold timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N        = 32,
  parameter int IDW      = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  // Counter only needs to reach MAX_HOLD-1; keep at least one bit when disabled.
  localparam int c_CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDW-1:0]     c_LAST_ID   = IDW'(N - 1);
  localparam logic [N-1:0]       c_ONE_HOT0  = N'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_ptr;
  logic [c_CNT_W-1:0] r_cnt;

  logic [IDW-1:0] w_ptr_next;
  logic           w_hit_limit;
  logic           w_release;
  logic [IDW-1:0] w_srch_ptr;
  logic [N-1:0]   w_srch_req;
  logic [N-1:0]   w_cand_hi;
  logic           w_hi_found;
  logic [IDW-1:0] w_hi_id;
  logic           w_lo_found;
  logic [IDW-1:0] w_lo_id;
  logic           w_win_found;
  logic [IDW-1:0] w_win_id;

  // Release bookkeeping: pointer successor of the holder and release causes.
  always_comb begin
    w_ptr_next  = (gnt_id == c_LAST_ID) ? '0 : gnt_id + IDW'(1);
    w_hit_limit = (MAX_HOLD != 0) && (r_cnt == c_HOLD_LAST);
    w_release   = done | ~req[gnt_id] | w_hit_limit;
  end

  // While busy the search runs from the post-release pointer with the holder
  // excluded, so a back-to-back grant can be loaded on the release edge.
  always_comb begin
    w_srch_ptr = (r_state == S_BUSY) ? w_ptr_next : r_ptr;
    w_srch_req = (r_state == S_BUSY) ? (req & ~gnt) : req;
    w_cand_hi  = w_srch_req & ({N{1'b1}} << w_srch_ptr);
  end

  // Lowest set index at/above the pointer wins, else lowest set index overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_found = 1'b0;
    w_lo_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_cand_hi[i]) begin
        w_hi_found = 1'b1;
        w_hi_id    = IDW'(i);
      end
      if (w_srch_req[i]) begin
        w_lo_found = 1'b1;
        w_lo_id    = IDW'(i);
      end
    end
    w_win_found = w_hi_found | w_lo_found;
    w_win_id    = w_hi_found ? w_hi_id : w_lo_id;
  end

  // Grant state machine with registered outputs, pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && w_win_found) begin
            r_state   <= S_BUSY;
            gnt       <= c_ONE_HOT0 << w_win_id;
            gnt_id    <= w_win_id;
            gnt_valid <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_BUSY: begin
          if (w_release) begin
            r_ptr   <= w_ptr_next;
            // An explicit done wins over a coincident counter expiry.
            timeout <= w_hit_limit & ~done;
            r_cnt   <= '0;
            if (en && w_win_found) begin
              gnt    <= c_ONE_HOT0 << w_win_id;
              gnt_id <= w_win_id;
            end else begin
              r_state   <= S_IDLE;
              gnt       <= '0;
              gnt_id    <= '0;
              gnt_valid <= 1'b0;
            end
          end else if (r_cnt != c_HOLD_LAST) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing one resource among N requesters, built around a masked priority-encode search. It converts a request vector into a registered one-hot grant plus binary grant index and holds the grant until release. A rotating pointer guarantees fairness, and a hold-timeout counter prevents any single requester from starving the others. It sits between requester logic and the shared datapath, and `gnt_id` drives the datapath's select.

## Interface
- `N`, 32: number of requesters (≥2).
- `IDW`, 5: index width, `$clog2(N)`.
- `MAX_HOLD`, 16: maximum grant length in cycles; 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  arbitration enable; 0 blocks new grants only.
- `req`  in  N  request vector, bit i = requester i.
- `done`  in  1  holder releases the resource this cycle.
- `gnt`  out  N  one-hot grant, registered.
- `gnt_id`  out  IDW  binary index of the granted requester, registered.
- `gnt_valid`  out  1  a grant is active; equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine has two states:
  - IDLE: no grant held.
  - BUSY: grant held by `gnt_id`.
- Arbitration search (combinational):
  - Candidate set = `req` masked to indices ≥ `ptr`.
  - If the set is non-empty, the winner is its lowest index.
  - Otherwise the winner is the lowest set index of the unmasked `req`.
  - If `req` = 0, there is no winner.
- IDLE → BUSY: `en`=1 and a winner exists. Register `gnt`, `gnt_id` and `gnt_valid`=1.
- Release condition in BUSY, any of:
  - `done`=1;
  - `req[gnt_id]`=0 (requester withdrew);
  - hold counter = `MAX_HOLD`-1 with `MAX_HOLD`≠0 (timeout).
- On release:
  - `ptr` ← (`gnt_id`+1) mod N. At `gnt_id`=N-1, `ptr` wraps to 0.
  - Arbitration is re-run in the same cycle with the updated pointer, excluding the releasing index.
  - If `en`=1 and a winner exists: stay BUSY and load the new grant next cycle (back-to-back, no bubble).
  - Otherwise go to IDLE and clear `gnt`, `gnt_id` and `gnt_valid`.
- `timeout` pulses for one cycle only when the release is caused by the counter.
  - If `done` is also 1 in that cycle, `done` takes precedence and `timeout` stays 0.
- Hold counter:
  - Cleared on every new grant.
  - Increments each BUSY cycle.
  - Saturates at `MAX_HOLD`-1.
- `en`=0 while BUSY: the current grant continues until its release, then the block goes to IDLE.
- `req` changes on non-granted bits while BUSY do not affect the grant.
- `ptr` is internal, reset to 0, and changes only on release.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - outputs: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `timeout`=0;
  - internal: state=IDLE, `ptr`=0, counter=0.
- Reset asserted mid-grant clears everything immediately, with no release pulse.
- The first grant after deassertion is searched from index 0.
- Request-to-grant latency is 1 cycle: `req` is sampled at edge k and `gnt` is valid after edge k.
- Release-to-next-grant latency is 1 cycle: `done` sampled at edge k gives the new `gnt` after edge k.
- A grant lasts at least 1 cycle. With timeout enabled it lasts at most `MAX_HOLD` cycles.
- `done` is ignored in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `req`=32'h0000_0001 with `en`=1:
  - next cycle `gnt`=32'h1, `gnt_id`=0, `gnt_valid`=1;
  - after pulsing `done`: `gnt`=0, `gnt_valid`=0.
- Fairness: `req`=32'h8000_0005 held, `done` pulsed every 2nd cycle → `gnt_id` sequence 0, 2, 31, 0, 2, … with no bubbles between grants.
- Wrap: after a grant to 31 is released, `req`=32'h8000_0002 → next `gnt_id`=1 (`ptr`=0).
- Timeout: `MAX_HOLD`=16, `req`=32'h0000_0110, `done` never asserted:
  - `gnt_id`=4 for exactly 16 cycles;
  - `timeout` pulses once;
  - then `gnt_id`=8.
- Withdrawal and enable:
  - `req[gnt_id]` dropped mid-grant → grant ends next cycle and the next requester is served;
  - with `en`=0 and `req`≠0 in IDLE → `gnt_valid` stays 0.
- Async reset while `gnt_id`=7 → outputs clear immediately; after deassert with `req`=32'h0000_0180 → `gnt_id`=7.
